sdram_slot_arbiter: RTL and testbench

//  Shares the single SDRAM controller between NPORTS requesters: CPU, video

---
 rtl/sdram_arb_pkg.sv | 20 ++
 rtl/sdram_slot_arbiter_chk.sv | 11 +
 rtl/sdram_slot_arbiter_rr_pick.sv | 31 +++
 rtl/sdram_slot_arbiter.sv | 159 +++++++++++++++
 tb/tb_sdram_slot_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM slot arbiter: default sizing, port roles
// and the slot FSM state encoding.
package sdram_arb_pkg;

    localparam int NPORTS_DEF     = 3;
    localparam int AW_DEF         = 25;
    localparam int RD_LAT_DEF     = 8;
    localparam int STARVE_MAX_DEF = 4;

    localparam int PORT_CPU = 0;
    localparam int PORT_VID = 1;
    localparam int PORT_DMA = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_slot_arbiter_chk.sv
// Protocol checker: a new slot must never start while an access is in flight.
module sdram_slot_arbiter_chk (
    input logic clk,
    input logic reset,
    input logic slot_start,
    input logic idle
);

    SLOT_OVERLAP: assert property (@(posedge clk) disable iff (reset) slot_start |-> idle);

endmodule

// File: rtl/sdram_slot_arbiter_rr_pick.sv
// Combinational round-robin pick over ports 1..NPORTS-1, starting at rr_ptr.
// Port 0 is never granted here; it is handled by fixed priority in the top.
module rr_pick #(
    parameter int NPORTS = 3,
    parameter int PW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req,
    input  logic [PW-1:0]     rr_ptr,
    output logic [NPORTS-1:0] grant
);

    // Walk the ring once from rr_ptr and take the first requester.
    always_comb begin
        logic          found;
        logic          hit;
        logic [PW-1:0] idx;
        int            base;
        grant = '0;
        found = 1'b0;
        hit   = 1'b0;
        idx   = '0;
        base  = (rr_ptr == '0) ? 1 : int'(rr_ptr);
        for (int k = 0; k < NPORTS - 1; k++) begin
            idx        = PW'(((base - 1 + k) % (NPORTS - 1)) + 1);
            hit        = !found && req[idx];
            grant[idx] = grant[idx] | hit;
            found      = found | hit;
        end
    end

endmodule

// File: rtl/sdram_slot_arbiter.sv
// Shares one SDRAM controller between NPORTS requesters, one access per slot,
// with fixed priority for port 0, round-robin for the rest and starvation forcing.
module sdram_slot_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS     = NPORTS_DEF,
    parameter int AW         = AW_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 slot_start,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    req_we,
    input  logic [NPORTS-1:0]    req_aux,
    input  logic [NPORTS*AW-1:0] req_addr,
    input  logic [NPORTS*8-1:0]  req_din,
    output logic [NPORTS-1:0]    done,
    output logic [15:0]          rdata,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_we,
    output logic [7:0]           mem_din,
    output logic                 mem_aux,
    input  logic [15:0]          mem_dout
);

    localparam int PW = $clog2(NPORTS);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int CW = $clog2(RD_LAT + 1);

    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    logic [PW-1:0]     rr_ptr_r;
    logic [SW-1:0]     starve_r [NPORTS];
    logic [NPORTS-1:0] win_r;

    logic [NPORTS-1:0] starved_s;
    logic [NPORTS-1:0] rr_grant_s;
    logic [NPORTS-1:0] win_oh_s;
    logic [PW-1:0]     win_idx_s;
    logic [PW-1:0]     rr_next_s;
    logic              win_valid_s;
    logic              arb_s;

    rr_pick #(.NPORTS(NPORTS), .PW(PW)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .grant  (rr_grant_s)
    );

    sdram_slot_arbiter_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .slot_start (slot_start),
        .idle       (state_r == IDLE)
    );

    // Starved ports outrank everything; the lowest index wins among them.
    always_comb begin
        win_idx_s   = '0;
        win_valid_s = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            starved_s[i] = req[i] && (starve_r[i] == SW'(STARVE_MAX));
        end
        if (|starved_s) begin
            for (int i = NPORTS - 1; i >= 0; i--) begin
                win_idx_s = starved_s[i] ? PW'(i) : win_idx_s;
            end
            win_valid_s = 1'b1;
        end else if (req[PORT_CPU]) begin
            win_idx_s   = PW'(PORT_CPU);
            win_valid_s = 1'b1;
        end else if (|rr_grant_s) begin
            for (int i = 0; i < NPORTS; i++) begin
                win_idx_s = rr_grant_s[i] ? PW'(i) : win_idx_s;
            end
            win_valid_s = 1'b1;
        end else begin
            win_valid_s = 1'b0;
        end
        win_oh_s  = win_valid_s ? (NPORTS'(1) << win_idx_s) : '0;
        rr_next_s = (win_idx_s == PW'(NPORTS - 1)) ? PW'(1) : win_idx_s + PW'(1);
        arb_s     = slot_start && (state_r == IDLE);
    end

    // Slot FSM, winner capture into the controller interface, done/rdata.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            rr_ptr_r <= PW'(1);
            win_r    <= '0;
            done     <= '0;
            rdata    <= 16'h0000;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            mem_din  <= 8'h00;
            mem_aux  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (arb_s && win_valid_s) begin
                        state_r  <= BUSY;
                        cnt_r    <= CW'(1);
                        win_r    <= win_oh_s;
                        rr_ptr_r <= rr_next_s;
                        mem_addr <= req_addr[win_idx_s*AW +: AW];
                        mem_we   <= req_we[win_idx_s];
                        mem_din  <= req_din[win_idx_s*8 +: 8];
                        mem_aux  <= req_aux[win_idx_s];
                    end else if (arb_s) begin
                        // Empty slot becomes a harmless read of the held address.
                        mem_we <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_r == CW'(RD_LAT)) begin
                        state_r <= DONE;
                        done    <= win_r;
                        if (!mem_we) begin
                            rdata <= mem_dout;
                        end else begin
                            rdata <= rdata;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done    <= '0;
                end
                default: begin
                    state_r <= IDLE;
                    done    <= '0;
                end
            endcase
        end
    end

    // Starvation counters: losers count up (saturating), winners and idle ports clear.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (reset || !req[i]) begin
                starve_r[i] <= '0;
            end else if (arb_s && win_oh_s[i]) begin
                starve_r[i] <= '0;
            end else if (arb_s && (starve_r[i] != SW'(STARVE_MAX))) begin
                starve_r[i] <= starve_r[i] + SW'(1);
            end else begin
                starve_r[i] <= starve_r[i];
            end
        end
    end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Self-checking bench for sdram_slot_arbiter: slot-level behavioural model with a
// per-cycle compare, plus hand-computed literal checks for the directed scenarios.
module tb_sdram_slot_arbiter;

    localparam int N      = 3;
    localparam int AW     = 25;
    localparam int RD_LAT = 8;
    localparam int SMAX   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            slot_start;
    logic [N-1:0]    req, req_we, req_aux;
    logic [N*AW-1:0] req_addr;
    logic [N*8-1:0]  req_din;
    logic [N-1:0]    done;
    logic [15:0]     rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [7:0]      mem_din;
    logic            mem_aux;
    logic [15:0]     mem_dout;

    always #5 clk = ~clk;

    // Controller read data model: a fixed function of the issued address.
    function automatic logic [15:0] ctrl_data(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hA15A;
    endfunction

    assign mem_dout = ctrl_data(mem_addr);

    sdram_slot_arbiter #(.NPORTS(N), .AW(AW), .RD_LAT(RD_LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset), .slot_start(slot_start),
        .req(req), .req_we(req_we), .req_aux(req_aux),
        .req_addr(req_addr), .req_din(req_din),
        .done(done), .rdata(rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_aux(mem_aux),
        .mem_dout(mem_dout)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    int m_starve [N];
    int m_rr, m_win, m_done_edge, m_free_edge;
    logic m_pending, m_win_we;
    logic [N-1:0]  e_done;
    logic [15:0]   e_rdata;
    logic [AW-1:0] e_addr;
    logic          e_we, e_aux;
    logic [7:0]    e_din;

    int grant_log [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Slot-level model: one decision per accepted slot, outcome due RD_LAT edges later.
    task automatic model_step();
        int pick;
        int p;
        if (reset) begin
            for (int i = 0; i < N; i++) m_starve[i] = 0;
            m_rr = 1; m_pending = 1'b0; m_free_edge = 0;
            e_done = '0; e_rdata = 16'h0000; e_addr = '0;
            e_we = 1'b0; e_aux = 1'b0; e_din = 8'h00;
            return;
        end
        e_done = '0;
        if (m_pending && cyc == m_done_edge) begin
            e_done[m_win] = 1'b1;
            if (!m_win_we) e_rdata = ctrl_data(e_addr);
            m_pending = 1'b0;
        end
        if (slot_start && cyc >= m_free_edge) begin
            pick = -1;
            for (int i = 0; i < N; i++)
                if (pick < 0 && req[i] && m_starve[i] == SMAX) pick = i;
            if (pick < 0 && req[0]) pick = 0;
            for (int k = 0; k < N - 1; k++) begin
                p = 1 + (m_rr - 1 + k) % (N - 1);
                if (pick < 0 && req[p]) pick = p;
            end
            for (int i = 0; i < N; i++)
                if (req[i]) m_starve[i] = (i == pick) ? 0 : ((m_starve[i] < SMAX) ? m_starve[i] + 1 : SMAX);
            if (pick >= 0) begin
                e_addr = req_addr[pick*AW +: AW];
                e_we   = req_we[pick];
                e_din  = req_din[pick*8 +: 8];
                e_aux  = req_aux[pick];
                m_win = pick; m_win_we = req_we[pick]; m_pending = 1'b1;
                m_done_edge = cyc + RD_LAT;
                m_free_edge = cyc + RD_LAT + 2;
                m_rr = (pick + 1 > N - 1) ? 1 : pick + 1;
            end else begin
                e_we = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) if (!req[i]) m_starve[i] = 0;
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step();
    end

    // Per-cycle compare against the model, and a log of serviced ports.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("done",     32'(done),     32'(e_done));
            chk("rdata",    32'(rdata),    32'(e_rdata));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_we",   32'(mem_we),   32'(e_we));
            chk("mem_din",  32'(mem_din),  32'(e_din));
            chk("mem_aux",  32'(mem_aux),  32'(e_aux));
        end
        for (int i = 0; i < N; i++) if (done[i]) grant_log.push_back(i);
    end

    int            s_cyc;
    logic [AW-1:0] s_addr;
    logic          s_we, s_aux;
    logic [7:0]    s_din;
    logic [N-1:0]  s_done;
    logic [15:0]   s_rdata;

    // One 14-clock slot; snapshots the interface at slot+1 and slot+9.
    task automatic run_slot();
        @(posedge clk); #1 slot_start = 1'b1; s_cyc = cyc;
        @(posedge clk); #1 slot_start = 1'b0;
        @(negedge clk);
        s_addr = mem_addr; s_we = mem_we; s_din = mem_din; s_aux = mem_aux;
        repeat (8) @(negedge clk);
        s_done = done; s_rdata = rdata;
        repeat (4) @(posedge clk);
    endtask

    task automatic chk_grants(input string name, input int base, input int exp_q [$]);
        chk({name, "_count"}, 32'(grant_log.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < grant_log.size()) chk(name, 32'(grant_log[base+i]), 32'(exp_q[i]));
    endtask

    initial begin
        int base;
        reset = 1'b1; slot_start = 1'b0;
        req = '0; req_we = '0; req_aux = '0; req_din = '0;
        req_addr = {25'h00F0F0F, 25'h01ABCDE, 25'h0000400};
        @(posedge clk); #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        reset = 1'b0;

        // 1: single read by the CPU port
        req[0] = 1'b1;
        run_slot();
        chk("t1_addr", 32'(s_addr), 32'h000400);
        chk("t1_we", 32'(s_we), 32'h0);
        chk("t1_done", 32'(s_done), 32'h1);
        chk("t1_rdata", 32'(s_rdata), 32'hA55A);
        chk("t1_latency", 32'(grant_log.size()), 32'd1);
        req[0] = 1'b0;

        // 2: write by the video port, rdata must hold
        req[1] = 1'b1; req_we[1] = 1'b1; req_aux[1] = 1'b1; req_din[15:8] = 8'h3C;
        run_slot();
        chk("t2_din", 32'(s_din), 32'h3C);
        chk("t2_aux", 32'(s_aux), 32'h1);
        chk("t2_we", 32'(s_we), 32'h1);
        chk("t2_done", 32'(s_done), 32'h2);
        chk("t2_rdata", 32'(s_rdata), 32'hA55A);
        req = '0; req_we = '0; req_aux = '0;

        // 3: full contention, starvation forces port 1 then port 2
        base = grant_log.size();
        req = 3'b111;
        repeat (6) run_slot();
        chk_grants("t3_order", base, '{0, 0, 0, 0, 1, 2});
        req = '0;

        // 4: ports 1 and 2 only, plain round-robin
        base = grant_log.size();
        req = 3'b110;
        repeat (4) run_slot();
        chk_grants("t4_order", base, '{1, 2, 1, 2});
        req = '0;

        // 5: empty slot
        base = grant_log.size();
        run_slot();
        chk("t5_we", 32'(s_we), 32'h0);
        chk("t5_addr", 32'(s_addr), 32'h0F0F0F);
        chk("t5_no_done", 32'(grant_log.size() - base), 32'd0);

        // 6: reset three clocks into a slot aborts it
        base = grant_log.size();
        req[2] = 1'b1;
        @(posedge clk); #1 slot_start = 1'b1;
        @(posedge clk); #1 slot_start = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("t6_rst_rdata", 32'(rdata), 32'h0);
        chk("t6_rst_done", 32'(done), 32'h0);
        reset = 1'b0;
        repeat (10) @(posedge clk);
        chk("t6_aborted", 32'(grant_log.size() - base), 32'd0);
        run_slot();
        chk("t6_retry_addr", 32'(s_addr), 32'h0F0F0F);
        chk("t6_retry_done", 32'(s_done), 32'h4);
        chk("t6_retry_rdata", 32'(s_rdata), 32'hAE55);
        req = '0;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
